adpcm_main_filtez_mac: RTL and testbench
========================================

// Module: adpcm_main_filtez_mac
// PURPOSE
//  Sequences the ADPCM zero-predictor sum zl = sum(bpl[i]*dlt[i]) >> SHIFT over NTAPS taps.
//  Reads coefficient and delay arrays through 1-cycle-latency memory ports.
//  Feeds the pipelined signed 32x11 multiplier (adpcm_main_mul_32s_11s_43_*) and accumulates its
//  43-bit products into a wide accumulator.
//  Returns the shifted, truncated 32-bit result with a start/done handshake.
// PARAMETERS
//  NTAPS     6   taps per run (1..64)
//  COEF_W    32  coefficient (bpl) width, signed
//  DLT_W     11  delay (dlt) width, signed
//  PROD_W    43  multiplier product width (COEF_W+DLT_W)
//  ACC_W     46  accumulator width; must be >= PROD_W+clog2(NTAPS)
//  SHIFT     14  arithmetic right shift applied to the final sum
//  MUL_LAT   1   multiplier register stages (din at cycle t -> dout at t+MUL_LAT, with ce=1)
//  ADDR_W    6   memory address width
// PORTS
//  clk       in   1        clock, rising edge
//  reset     in   1        asynchronous, active-low reset
//  start     in   1        request a run; sampled only while idle=1
//  idle      out  1        1 in IDLE state
//  done      out  1        one-cycle pulse: result valid
//  result    out  32       (acc >>> SHIFT)[31:0], held until next done
//  coef_addr out  ADDR_W   bpl read address
//  coef_ce   out  1        bpl read enable
//  coef_q    in   COEF_W   bpl data, valid 1 cycle after coef_ce
//  dlt_addr  out  ADDR_W   dlt read address (always equal to coef_addr)
//  dlt_ce    out  1        dlt read enable (always equal to coef_ce)
//  dlt_q     in   DLT_W    dlt data, valid 1 cycle after dlt_ce
//  mul_ce    out  1        multiplier clock enable
//  mul_din0  out  COEF_W   = coef_q, unregistered
//  mul_din1  out  DLT_W    = dlt_q, unregistered
//  mul_dout  in   PROD_W   signed product from multiplier
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE, idle=1, done=0, result=0.
//   Also clears acc, tap counter, addresses, ce outputs and the valid shift register.
//  FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//  - IDLE: on start=1, clear acc, tap cnt=0 -> RUN. start outside IDLE is ignored (no queuing).
//  - RUN: coef_ce=dlt_ce=1 and addr=cnt each cycle; cnt increments.
//    After address NTAPS-1 is issued -> DRAIN.
//  - DRAIN: ce low, addresses hold.
//    Waits until the last product has been accumulated -> DONE.
//  - DONE: done=1 for exactly this cycle -> IDLE. start is not sampled here.
//  - mul_ce=1 in RUN and DRAIN, 0 otherwise.
//  Product tracking: valid shift register of depth 1+MUL_LAT, fed by the read enable.
//   acc += sign_extend(mul_dout) whenever the tail bit is 1.
//  Timing (c0 = cycle start is sampled in IDLE):
//   - tap k address in c(1+k); product accumulated at end of c(2+MUL_LAT+k).
//   - done and result are registered from the final acc+product.
//     done is high in c(NTAPS+MUL_LAT+2): c9 with defaults.
//   - next start sampled no earlier than c(NTAPS+MUL_LAT+3).
//  Arithmetic: all signed two's complement.
//   - result = floor(acc / 2^SHIFT) truncated to low 32 bits; no saturation.
//   - acc never overflows under the ACC_W rule.
//  Reset mid-run: abort immediately; no done pulse; result cleared to 0.
// TESTING
//  1 bpl[i]=16384, dlt[i]=1 for all 6 taps; start at c0 -> done only in c9, result=6, idle=1 in c10.
//  2 bpl[i]=-32768, dlt[i]=-1024 for all taps -> result=12288 (0x00003000).
//  3 bpl[0]=-1, dlt[0]=1, other taps 0 -> result=-1 (0xFFFFFFFF): arithmetic shift floors.
//  4 bpl[i]=0x7FFFFFFF, dlt[i]=-1024 for all taps -> result=-805306368 (0xD0000000): no acc overflow.
//  5 start held high continuously -> done in c9 and c19; addresses 0..5 in c1..c6 and c11..c16.
//  6 reset asserted in c4 of a run -> idle=1, done=0, result=0 immediately.
//    Next run with test-1 data -> result=6.

Source files
------------

// File: rtl/adpcm_main_filtez_mac.sv
// Zero-predictor MAC: sequences NTAPS coefficient/delay reads through an external multiplier, returns (sum >>> SHIFT).
// Latency: done pulses NTAPS+MUL_LAT+2 cycles after start is sampled; no backpressure, start is ignored unless idle.
module adpcm_main_filtez_mac #(
    parameter int NTAPS   = 6,
    parameter int COEF_W  = 32,
    parameter int DLT_W   = 11,
    parameter int PROD_W  = 43,
    parameter int ACC_W   = 46,
    parameter int SHIFT   = 14,
    parameter int MUL_LAT = 1,
    parameter int ADDR_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              idle,
    output logic              done,
    output logic [31:0]       result,
    output logic [ADDR_W-1:0] coef_addr,
    output logic              coef_ce,
    input  logic [COEF_W-1:0] coef_q,
    output logic [ADDR_W-1:0] dlt_addr,
    output logic              dlt_ce,
    input  logic [DLT_W-1:0]  dlt_q,
    output logic              mul_ce,
    output logic [COEF_W-1:0] mul_din0,
    output logic [DLT_W-1:0]  mul_din1,
    input  logic [PROD_W-1:0] mul_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NTAPS - 1);

    state_t                    r_state;
    state_t                    w_next;
    logic [ADDR_W-1:0]         r_addr;
    logic                      r_ce;
    logic [MUL_LAT:0]          r_vld;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_done;
    logic [31:0]               r_result;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_sum;
    logic [31:0]               w_res;
    logic                      w_last_prod;

    // Tail bit marks a product on mul_dout; the final one is the tail with nothing queued behind it.
    assign w_prod_ext  = {{(ACC_W-PROD_W){mul_dout[PROD_W-1]}}, mul_dout};
    assign w_sum       = r_acc + w_prod_ext;
    assign w_res       = 32'(w_sum >>> SHIFT);
    assign w_last_prod = r_vld[MUL_LAT] & ~(|r_vld[MUL_LAT-1:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_addr == LAST_ADDR) w_next = S_DRAIN;
            S_DRAIN: if (w_last_prod) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr   <= '0;
            r_ce     <= 1'b0;
            r_vld    <= '0;
            r_acc    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_vld  <= {r_vld[MUL_LAT-1:0], r_ce};
            r_done <= (r_state == S_DRAIN) && w_last_prod;

            if (r_state == S_IDLE && start) begin
                r_acc <= '0;
            end else if (r_vld[MUL_LAT]) begin
                r_acc <= w_sum;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ce   <= 1'b1;
                        r_addr <= '0;
                    end
                end
                S_RUN: begin
                    if (r_addr == LAST_ADDR) begin
                        r_ce <= 1'b0;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_last_prod) r_result <= w_res;
                end
                default: ;
            endcase
        end
    end

    assign idle      = (r_state == S_IDLE);
    assign done      = r_done;
    assign result    = r_result;
    assign coef_addr = r_addr;
    assign dlt_addr  = r_addr;
    assign coef_ce   = r_ce;
    assign dlt_ce    = r_ce;
    assign mul_ce    = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign mul_din0  = coef_q;
    assign mul_din1  = dlt_q;

endmodule

// File: tb/tb_adpcm_main_filtez_mac.sv
// Directed bench for adpcm_main_filtez_mac with behavioural memories and a 1-stage signed multiplier.
module tb_adpcm_main_filtez_mac;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               idle, done, coef_ce, dlt_ce, mul_ce;
    logic [31:0]        result;
    logic [5:0]         coef_addr, dlt_addr;
    logic [31:0]        coef_q = '0;
    logic [10:0]        dlt_q = '0;
    logic [31:0]        mul_din0;
    logic [10:0]        mul_din1;
    logic signed [42:0] mul_dout = '0;

    logic signed [31:0] bpl [64];
    logic signed [10:0] dlt [64];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    adpcm_main_filtez_mac dut (
        .clk(clk), .reset(reset), .start(start), .idle(idle), .done(done),
        .result(result), .coef_addr(coef_addr), .coef_ce(coef_ce), .coef_q(coef_q),
        .dlt_addr(dlt_addr), .dlt_ce(dlt_ce), .dlt_q(dlt_q), .mul_ce(mul_ce),
        .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout)
    );

    always @(posedge clk) begin
        if (coef_ce) coef_q <= bpl[coef_addr];
        if (dlt_ce)  dlt_q  <= dlt[dlt_addr];
        if (mul_ce)  mul_dout <= $signed(mul_din0) * $signed(mul_din1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic signed [31:0] b0, input logic signed [10:0] d0,
                        input logic signed [31:0] br, input logic signed [10:0] dr);
        for (int i = 0; i < 64; i++) begin
            bpl[i] = (i == 0) ? b0 : br;
            dlt[i] = (i == 0) ? d0 : dr;
        end
    endtask

    // One run from an idle DUT: done must appear only in c9, idle again in c10.
    task automatic do_run(input string tag, input logic [31:0] exp_res);
        int done_cyc = -1;
        int ndone = 0;
        logic idle_c10 = 1'b0;
        logic mce_c7 = 1'b0;
        logic mce_c9 = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c == 7)  mce_c7 = mul_ce;
            if (c == 9)  mce_c9 = mul_ce;
            if (c == 10) idle_c10 = idle;
        end
        chk({tag, "_done_cycle"}, 32'(done_cyc), 32'd9);
        chk({tag, "_done_count"}, 32'(ndone), 32'd1);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_idle_c10"}, {31'b0, idle_c10}, 32'd1);
        chk({tag, "_mulce_c7_c9"}, {30'b0, mce_c7, mce_c9}, 32'b10);
    endtask

    initial begin
        fill(32'sd16384, 11'sd1, 32'sd16384, 11'sd1);
        repeat (3) @(negedge clk);
        chk("rst_idle", {31'b0, idle}, 32'd1);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_ce", {29'b0, coef_ce, dlt_ce, mul_ce}, 32'd0);
        reset = 1'b1;

        do_run("t1", 32'd6);

        fill(-32'sd32768, -11'sd1024, -32'sd32768, -11'sd1024);
        do_run("t2", 32'h0000_3000);

        fill(-32'sd1, 11'sd1, 32'sd0, 11'sd0);
        do_run("t3", 32'hFFFF_FFFF);

        fill(32'sh7FFF_FFFF, -11'sd1024, 32'sh7FFF_FFFF, -11'sd1024);
        do_run("t4", 32'hD000_0000);

        // Start held high: back-to-back runs with a one-cycle idle gap.
        fill(32'sd16384, 11'sd1, 32'sd16384, 11'sd1);
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            logic       exp_ce;
            logic [5:0] exp_addr;
            @(negedge clk);
            exp_ce   = (c >= 1 && c <= 6) || (c >= 11 && c <= 16);
            exp_addr = (c <= 6) ? 6'(c - 1) : 6'(c - 11);
            chk($sformatf("t5_done_c%0d", c), {31'b0, done}, {31'b0, (c == 9 || c == 19)});
            if (exp_ce)
                chk($sformatf("t5_addr_c%0d", c), {18'b0, coef_ce, dlt_ce, coef_addr, dlt_addr},
                    {18'b0, 2'b11, exp_addr, exp_addr});
            else
                chk($sformatf("t5_ce_c%0d", c), {30'b0, coef_ce, dlt_ce}, 32'd0);
        end
        start = 1'b0;
        chk("t5_result", result, 32'd6);

        // Asynchronous reset in c4 of a run.
        fill(-32'sd32768, -11'sd1024, -32'sd32768, -11'sd1024);
        do_run("t6_pre", 32'h0000_3000);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_idle", {31'b0, idle}, 32'd1);
        chk("t6_done", {31'b0, done}, 32'd0);
        chk("t6_result", result, 32'd0);
        chk("t6_ce", {29'b0, coef_ce, dlt_ce, mul_ce}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        fill(32'sd16384, 11'sd1, 32'sd16384, 11'sd1);
        do_run("t6_post", 32'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
